// File: rtl/tile_spawner_pkg.sv
// tile_spawner_pkg
//   Shared game definitions: board geometry, tile exponent codes, spawner
//   state encoding and a helper that extracts one cell from the packed board.
//   No ports.
package tile_spawner_pkg;

  localparam int BOARD_CELLS = 16;
  localparam int POS_W       = 4;
  localparam int VAL_W       = 4;
  localparam int BOARD_W     = BOARD_CELLS * VAL_W;

  // Tiles are stored as log2 exponents; 0 marks an empty cell.
  localparam logic [VAL_W-1:0] EXP_EMPTY = 4'd0;
  localparam logic [VAL_W-1:0] EXP_TWO   = 4'd1;
  localparam logic [VAL_W-1:0] EXP_FOUR  = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } spawn_state_t;

  // Cell i lives in bits [i*VAL_W +: VAL_W] of the packed board.
  function automatic logic [VAL_W-1:0] cell_at(input logic [BOARD_W-1:0] board,
                                               input logic [POS_W-1:0]   idx);
    return board[int'(idx)*VAL_W +: VAL_W];
  endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// tile_spawner_if
//   Request/board/write-port bundle between the game controller side and the
//   tile spawner.
//   master : drives spawn_req, rand_pos, rand_four, board_in;
//            observes busy, wr_en, wr_addr, wr_data, done, full.
//   slave  : the spawner itself (directions reversed).
interface tile_spawner_if;
  import tile_spawner_pkg::*;

  logic               spawn_req;
  logic [POS_W-1:0]   rand_pos;
  logic               rand_four;
  logic [BOARD_W-1:0] board_in;
  logic               busy;
  logic               wr_en;
  logic [POS_W-1:0]   wr_addr;
  logic [VAL_W-1:0]   wr_data;
  logic               done;
  logic               full;

  modport master (
    output spawn_req, rand_pos, rand_four, board_in,
    input  busy, wr_en, wr_addr, wr_data, done, full
  );

  modport slave (
    input  spawn_req, rand_pos, rand_four, board_in,
    output busy, wr_en, wr_addr, wr_data, done, full
  );

endinterface

// File: rtl/tile_spawner.sv
// tile_spawner
//   On a spawn request, snapshots the board, starts at the random cell and
//   scans circularly for the first empty cell, then writes a 2 or 4 tile
//   there through a one-cycle write strobe, or reports the board full.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : tile_spawner_if.slave (request inputs, board snapshot source,
//             busy/write-port/done/full outputs, all registered)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for spawn_req; busy low
//   ST_SCAN  | stepping through snapshot cells, one per cycle
//   ST_WRITE | wr_en/done high for one cycle, then back to idle
//   ST_FULL  | done/full high for one cycle, no write, then back to idle
module tile_spawner
  import tile_spawner_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  tile_spawner_if.slave bus
);

  localparam logic [POS_W-1:0] CNT_LAST = POS_W'(BOARD_CELLS - 1);

  spawn_state_t       state_q,   state_d;
  logic [POS_W-1:0]   ptr_q,     ptr_d;
  logic [POS_W-1:0]   cnt_q,     cnt_d;
  logic [VAL_W-1:0]   val_q,     val_d;
  logic [BOARD_W-1:0] snap_q,    snap_d;
  logic [VAL_W-1:0]   cell_q,    cell_d;
  logic [POS_W-1:0]   addr_q,    addr_d;
  logic               look_q,    look_d;
  logic               busy_q,    busy_d;
  logic               wr_en_q,   wr_en_d;
  logic [POS_W-1:0]   wr_addr_q, wr_addr_d;
  logic [VAL_W-1:0]   wr_data_q, wr_data_d;
  logic               done_q,    done_d;
  logic               full_q,    full_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      val_q     <= '0;
      snap_q    <= '0;
      cell_q    <= '0;
      addr_q    <= '0;
      look_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      snap_q    <= snap_d;
      cell_q    <= cell_d;
      addr_q    <= addr_d;
      look_q    <= look_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      full_q    <= full_d;
    end
  end

  // The 16:1 cell mux is registered (cell_q/addr_q) before the empty test, so
  // each cell is fetched one cycle and judged the next; look_q marks that the
  // fetch stage holds a real cell. This gives the k+2 write latency.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    snap_d    = snap_q;
    cell_d    = cell_q;
    addr_d    = addr_q;
    look_d    = look_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    full_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.spawn_req) begin
          state_d = ST_SCAN;
          ptr_d   = bus.rand_pos;
          snap_d  = bus.board_in;
          val_d   = bus.rand_four ? EXP_FOUR : EXP_TWO;
          cnt_d   = '0;
          look_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SCAN: begin
        cell_d = cell_at(snap_q, ptr_q);
        addr_d = ptr_q;
        look_d = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (look_q) begin
          if (cell_q == EXP_EMPTY) begin
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = val_q;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_FULL;
            done_d  = 1'b1;
            full_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WRITE, ST_FULL: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;
  assign bus.full    = full_q;

endmodule

// File: doc/tile_spawner.md
Name: tile_spawner

Overview:
- Consumer of the free-running 4-bit board position generator.
- On a spawn request, takes the current position as a random start cell, then scans the 4x4 board circularly from there for the first empty cell.
- Writes a new tile (2 or 4) into that cell through a single-cycle write port, or reports the board full.
- Sits between the position generator and the board register file; the game-control FSM drives it after each valid move.

Parameters:
- N_CELLS, 16, number of board cells; must equal 2**POS_W.
- POS_W, 4, cell index width; matches the position generator output.
- VAL_W, 4, tile field width. Each tile is stored as a log2 exponent; 0 = empty.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spawn_req  in  1  level sampled at each edge; accepted only when busy=0.
- rand_pos  in  POS_W  start cell from the position generator; sampled on accept.
- rand_four  in  1  1 = spawn a 4 (exponent 2), 0 = spawn a 2 (exponent 1); sampled on accept.
- board_in  in  N_CELLS*VAL_W  board contents; cell i occupies bits [i*VAL_W +: VAL_W]; snapshotted on accept.
- busy  out  1  high from accept until the cycle after done.
- wr_en  out  1  one-cycle write strobe to the board.
- wr_addr  out  POS_W  cell written; valid when wr_en=1.
- wr_data  out  VAL_W  exponent written; valid when wr_en=1.
- done  out  1  one-cycle completion pulse.
- full  out  1  qualifies done: no empty cell was found, no write occurred.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy, wr_en, done, full = 0. wr_addr = 0, wr_data = 0. Internal ptr and cnt = 0.
- All outputs are registered.
- States: IDLE, SCAN, WRITE, FULL.
- IDLE:
  - spawn_req=1 at edge 0 → latch ptr=rand_pos, snapshot board_in, latch val = rand_four ? 2 : 1, cnt=0.
  - Go to SCAN; busy=1 from edge 0.
- SCAN: examines snapshot cell ptr once per cycle.
  - Cell is 0 → go to WRITE, driving wr_en=1, done=1, wr_addr=ptr, wr_data=val.
  - Cell is nonzero and cnt=N_CELLS-1 → go to FULL, driving done=1, full=1, wr_en=0.
  - Otherwise → ptr=ptr+1 modulo N_CELLS (15 wraps to 0), cnt=cnt+1.
- Latency:
  - First empty cell at circular offset k (0..15) from rand_pos → wr_en/done high during the cycle after edge k+2, exactly one cycle.
  - Full board → done/full high during the cycle after edge 17.
- WRITE and FULL last one cycle, then return to IDLE.
  - busy drops at the following edge: k+3 for a write, 18 for full.
  - wr_en, done and full drop at that same edge.
- spawn_req while busy=1, including the done cycle, is ignored. It is not queued.
- board_in, rand_pos and rand_four changes after accept have no effect; the scan uses snapshots only.
- At most one write per request. A cell is never written with 0. The write address is always a cell that was empty in the snapshot.
- rst_n low mid-scan or in the WRITE cycle → immediate return to reset values; no write is issued after reset assertion.

Decomposition:
- Shared game package holds:
  - BOARD_CELLS=16, POS_W=4, VAL_W=4
  - EXP_EMPTY=0, EXP_TWO=1, EXP_FOUR=2
  - cell-slice helper for board_in indexing
  - state encoding typedef for IDLE/SCAN/WRITE/FULL
- No sub-module needed. Cell selection is a VAL_W-wide N_CELLS:1 mux inside the block.

Test Plan:
- Empty board, rand_pos=5, rand_four=0, req at edge 0 → wr_en=1, wr_addr=5, wr_data=1, done=1 in the cycle after edge 2; busy=0 after edge 3.
- Cells 14, 15, 0, 1 nonzero, cell 2 empty, rand_pos=14, rand_four=1 → wraps; wr_addr=2, wr_data=2, wr_en after edge 6 (k=4).
- All 16 cells nonzero, rand_pos=9 → done=1, full=1, wr_en=0 after edge 17; busy=0 after edge 18.
- Only cell 8 empty, rand_pos=9 → k=15, wr_addr=8 after edge 17.
- Req held high continuously, board empty → second accept only at the edge where busy=0; exactly one wr_en per accept.
- board_in cleared mid-scan after accept, start rand_pos=3, cells 3-6 full, cell 7 empty → still writes cell 7. Separately, rst_n pulsed low during SCAN → all outputs 0 immediately and no wr_en afterwards.
